// File: rtl/irq_ctrl.sv
// irq_ctrl: 10-line interrupt controller with mask/pending/edge CSRs and CPU acknowledge.
// Optional macro IRQ_CTRL_EDGE_EN enables per-line edge mode; without it every line is level.
`default_nettype none

module irq_ctrl #(
    parameter logic [5:0] base_addr = 6'h1E
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [5:0] io_a,
    input  logic       io_we,
    input  logic       io_re,
    input  logic [7:0] io_di,
    output logic [7:0] io_do,
    input  logic [9:0] irq_src,
    output logic [9:0] irq_lines,
    input  logic       irqack,
    input  logic [3:0] irqackad,
    output logic [9:0] src_ack
);

    logic [9:0] sync1_q, sync2_q;
    logic [9:0] pend_q, pend_d;
    logic [9:0] mask_q, mask_d;
    logic [9:0] lines_q;
    logic [9:0] ack_q, ack_d;
    logic [9:0] edge_sel;
    logic [5:0] off;
    logic       hit;

    // Offset relative to the block base; wraps harmlessly for addresses below base.
    assign off = io_a - base_addr;
    assign hit = (off < 6'd6);

    always_comb begin
        mask_d = mask_q;
        if (io_we && off == 6'd0) mask_d[7:0] = io_di;
        if (io_we && off == 6'd1) mask_d[9:8] = io_di[1:0];
    end

    always_comb begin
        ack_d = '0;
        for (int i = 0; i < 10; i++) begin
            if (irqack && irqackad == 4'(i + 1)) ack_d[i] = 1'b1;
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [9:0] edge_q, edge_d;
    logic [9:0] prev_q;
    logic [9:0] rise, w1c, clr;

    assign edge_sel = edge_q;

    always_comb begin
        edge_d = edge_q;
        if (io_we && off == 6'd4) edge_d[7:0] = io_di;
        if (io_we && off == 6'd5) edge_d[9:8] = io_di[1:0];
    end

    assign rise = sync2_q & ~prev_q;
    assign w1c  = {(io_we && off == 6'd3) ? io_di[1:0] : 2'b00,
                   (io_we && off == 6'd2) ? io_di      : 8'h00};
    assign clr  = w1c | ack_d;

    // A new rising edge dominates any clear arriving in the same cycle.
    assign pend_d = (edge_q & (rise | (pend_q & ~clr))) | (~edge_q & sync2_q);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            edge_q <= '0;
            prev_q <= '0;
        end else begin
            edge_q <= edge_d;
            prev_q <= sync2_q;
        end
    end
`else
    assign edge_sel = '0;
    assign pend_d   = sync2_q;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            lines_q <= '0;
            ack_q   <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            lines_q <= pend_q & mask_q;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        io_do = 8'h00;
        if (io_re && hit) begin
            case (off)
                6'd0:    io_do = mask_q[7:0];
                6'd1:    io_do = {6'b0, mask_q[9:8]};
                6'd2:    io_do = pend_q[7:0];
                6'd3:    io_do = {6'b0, pend_q[9:8]};
                6'd4:    io_do = edge_sel[7:0];
                6'd5:    io_do = {6'b0, edge_sel[9:8]};
                default: io_do = 8'h00;
            endcase
        end
    end

    assign irq_lines = lines_q;
    assign src_ack   = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (level build, plus edge tests when IRQ_CTRL_EDGE_EN is set).
`default_nettype none

module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] io_a;
    logic       io_we, io_re;
    logic [7:0] io_di;
    logic [7:0] io_do;
    logic [9:0] irq_src;
    logic [9:0] irq_lines;
    logic       irqack;
    logic [3:0] irqackad;
    logic [9:0] src_ack;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] A_IMSK_L = 6'h1E;
    localparam logic [5:0] A_IMSK_H = 6'h1F;
    localparam logic [5:0] A_IPND_L = 6'h20;
    localparam logic [5:0] A_IPND_H = 6'h21;
    localparam logic [5:0] A_IEDG_L = 6'h22;

    irq_ctrl #(.base_addr(6'h1E)) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .io_a      (io_a),
        .io_we     (io_we),
        .io_re     (io_re),
        .io_di     (io_di),
        .io_do     (io_do),
        .irq_src   (irq_src),
        .irq_lines (irq_lines),
        .irqack    (irqack),
        .irqackad  (irqackad),
        .src_ack   (src_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_a = a; io_di = d; io_we = 1'b1;
        tick();
        io_we = 1'b0; io_di = 8'h00;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        io_a = a; io_re = 1'b1;
        #1;
        d = io_do;
        io_re = 1'b0;
    endtask

    task automatic ack(input logic [3:0] n);
        irqack = 1'b1; irqackad = n;
        tick();
        irqack = 1'b0; irqackad = 4'd0;
    endtask

    task automatic do_reset();
        irq_src = '0; io_we = 0; io_re = 0; io_a = '0; io_di = '0;
        irqack = 0; irqackad = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        irq_src = '0; io_we = 0; io_re = 0; io_a = A_IMSK_L; io_di = '0;
        irqack = 0; irqackad = '0;
        rst = 1'b1;
        tick();
        checks++; if (irq_lines !== 10'h000) begin failures++; $display("FAIL rst_lines got=%h exp=%h", irq_lines, 10'h000); end
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL rst_src_ack got=%h exp=%h", src_ack, 10'h000); end
        checks++; if (io_do !== 8'h00) begin failures++; $display("FAIL rst_io_do_idle got=%h exp=%h", io_do, 8'h00); end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            rd(A_IMSK_L + 6'(i), v);
            checks++; if (v !== 8'h00) begin failures++; $display("FAIL rst_reg%0d got=%h exp=%h", i, v, 8'h00); end
        end
    endtask

    task automatic test_mask_rw();
        logic [7:0] v;
        do_reset();
        wr(A_IMSK_L, 8'hA5);
        rd(A_IMSK_L, v);
        checks++; if (v !== 8'hA5) begin failures++; $display("FAIL imsk_l_rw got=%h exp=%h", v, 8'hA5); end
        wr(A_IMSK_H, 8'hFF);
        rd(A_IMSK_H, v);
        checks++; if (v !== 8'h03) begin failures++; $display("FAIL imsk_h_rw got=%h exp=%h", v, 8'h03); end
        wr(6'h24, 8'h5A);
        wr(6'h1D, 8'h5A);
        rd(A_IMSK_L, v);
        checks++; if (v !== 8'hA5) begin failures++; $display("FAIL out_of_map_wr got=%h exp=%h", v, 8'hA5); end
        rd(6'h24, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL out_of_map_rd got=%h exp=%h", v, 8'h00); end
        io_a = A_IMSK_L; #1;
        checks++; if (io_do !== 8'h00) begin failures++; $display("FAIL io_do_no_re got=%h exp=%h", io_do, 8'h00); end
    endtask

    task automatic test_level();
        logic [7:0] v;
        do_reset();
        wr(A_IMSK_H, 8'h02);
        irq_src[9] = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (irq_lines !== 10'h200) begin failures++; $display("FAIL lvl_lines_on got=%h exp=%h", irq_lines, 10'h200); end
        wr(A_IPND_H, 8'h02);
        tick();
        rd(A_IPND_H, v);
        checks++; if (v !== 8'h02) begin failures++; $display("FAIL lvl_w1c_ignored got=%h exp=%h", v, 8'h02); end
        checks++; if (irq_lines !== 10'h200) begin failures++; $display("FAIL lvl_lines_after_w1c got=%h exp=%h", irq_lines, 10'h200); end
        irq_src[9] = 1'b0;
        tick(); tick(); tick();
        rd(A_IPND_H, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL lvl_pnd_drop got=%h exp=%h", v, 8'h00); end
        checks++; if (irq_lines !== 10'h200) begin failures++; $display("FAIL lvl_lines_lag got=%h exp=%h", irq_lines, 10'h200); end
        tick();
        checks++; if (irq_lines !== 10'h000) begin failures++; $display("FAIL lvl_lines_off got=%h exp=%h", irq_lines, 10'h000); end
        // Ack on a level line must not clear pending
        wr(A_IMSK_L, 8'h08);
        irq_src[3] = 1'b1;
        tick(); tick(); tick();
        ack(4'd4);
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h08) begin failures++; $display("FAIL lvl_ack_ignored got=%h exp=%h", v, 8'h08); end
        irq_src = '0;
        // Mask clear drops the line but keeps pending
        wr(A_IMSK_L, 8'h00);
        tick();
        rd(A_IPND_L, v);
        checks++; if (irq_lines !== 10'h000) begin failures++; $display("FAIL mask_clear_lines got=%h exp=%h", irq_lines, 10'h000); end
    endtask

    task automatic test_ack();
        do_reset();
        ack(4'd6);
        checks++; if (src_ack !== 10'h020) begin failures++; $display("FAIL ack6_pulse got=%h exp=%h", src_ack, 10'h020); end
        tick();
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL ack6_one_cycle got=%h exp=%h", src_ack, 10'h000); end
        ack(4'd10);
        checks++; if (src_ack !== 10'h200) begin failures++; $display("FAIL ack10_pulse got=%h exp=%h", src_ack, 10'h200); end
        ack(4'd1);
        checks++; if (src_ack !== 10'h001) begin failures++; $display("FAIL ack1_pulse got=%h exp=%h", src_ack, 10'h001); end
        ack(4'd0);
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL ack0_ignored got=%h exp=%h", src_ack, 10'h000); end
        ack(4'd11);
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL ack11_ignored got=%h exp=%h", src_ack, 10'h000); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        do_reset();
        wr(A_IMSK_L, 8'hFF);
        wr(A_IMSK_H, 8'h03);
        irq_src = 10'h104;
        tick(); tick(); tick(); tick();
        checks++; if (irq_lines !== 10'h104) begin failures++; $display("FAIL mid_lines_before got=%h exp=%h", irq_lines, 10'h104); end
        #2 rst = 1'b1;
        #1;
        checks++; if (irq_lines !== 10'h000) begin failures++; $display("FAIL mid_lines_async got=%h exp=%h", irq_lines, 10'h000); end
        irq_src = '0;
        tick();
        rst = 1'b0;
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_ipnd_l got=%h exp=%h", v, 8'h00); end
        rd(A_IPND_H, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL mid_ipnd_h got=%h exp=%h", v, 8'h00); end
        tick();
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL mid_no_ack_release got=%h exp=%h", src_ack, 10'h000); end
        ack(4'd12);
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL mid_ack12 got=%h exp=%h", src_ack, 10'h000); end
    endtask

`ifdef IRQ_CTRL_EDGE_EN
    task automatic test_edge();
        logic [7:0] v;
        do_reset();
        wr(A_IMSK_L, 8'h20);
        wr(A_IEDG_L, 8'h20);
        irq_src[5] = 1'b1;
        tick();
        irq_src[5] = 1'b0;
        tick(); tick();
        checks++; if (irq_lines !== 10'h000) begin failures++; $display("FAIL edge_lines_early got=%h exp=%h", irq_lines, 10'h000); end
        tick();
        checks++; if (irq_lines !== 10'h020) begin failures++; $display("FAIL edge_lines_set got=%h exp=%h", irq_lines, 10'h020); end
        tick(); tick();
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h20) begin failures++; $display("FAIL edge_pnd_held got=%h exp=%h", v, 8'h20); end
        ack(4'd6);
        checks++; if (src_ack !== 10'h020) begin failures++; $display("FAIL edge_ack_pulse got=%h exp=%h", src_ack, 10'h020); end
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL edge_ack_clear got=%h exp=%h", v, 8'h00); end
        tick();
        checks++; if (irq_lines !== 10'h000) begin failures++; $display("FAIL edge_lines_clear got=%h exp=%h", irq_lines, 10'h000); end
        checks++; if (src_ack !== 10'h000) begin failures++; $display("FAIL edge_ack_end got=%h exp=%h", src_ack, 10'h000); end
    endtask

    task automatic test_set_wins();
        logic [7:0] v;
        do_reset();
        wr(A_IEDG_L, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick(); tick(); tick();
        wr(A_IPND_L, 8'h00);
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL w1c_zero got=%h exp=%h", v, 8'h01); end
        wr(A_IPND_L, 8'h01);
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", v, 8'h00); end
        // Re-arm, then let a fresh edge coincide with the W1C edge
        wr(A_IEDG_L, 8'h01);
        irq_src[0] = 1'b1;
        tick(); tick();
        wr(A_IPND_L, 8'h01);
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL set_wins got=%h exp=%h", v, 8'h01); end
        irq_src[0] = 1'b0;
    endtask
`else
    task automatic test_no_edge();
        logic [7:0] v;
        do_reset();
        wr(A_IEDG_L, 8'hFF);
        rd(A_IEDG_L, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL iedg_reads_zero got=%h exp=%h", v, 8'h00); end
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick(); tick();
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h01) begin failures++; $display("FAIL lvl_pulse_seen got=%h exp=%h", v, 8'h01); end
        tick();
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL lvl_pulse_gone got=%h exp=%h", v, 8'h00); end
        tick(); tick();
        rd(A_IPND_L, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL lvl_pulse_final got=%h exp=%h", v, 8'h00); end
    endtask
`endif

    initial begin
        test_reset();
        test_mask_rw();
        test_level();
        test_ack();
`ifdef IRQ_CTRL_EDGE_EN
        test_edge();
        test_set_wins();
`else
        test_no_edge();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
